// File: rtl/tinyrv_pkg.sv
// tinyrv_pkg: shared FSM states, bus phase encodings and wait-counter width for the memory bridge
package tinyrv_pkg;
    localparam int WAIT_W = 4;
    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, RESP} state_t;
    localparam logic BYTE_HI = 1'b0;
    localparam logic BYTE_LO = 1'b1;
    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;
endpackage

// File: rtl/tinyrv_mem_bridge_wait_ctr.sv
// tinyrv_mem_bridge_wait_ctr: per-data-phase wait counter; TINYRV_MEM_BRIDGE_RDY_EN also gates phase end on bus_rdy_i
module tinyrv_mem_bridge_wait_ctr
    import tinyrv_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic rdy,
    output logic done
);
    logic [WAIT_W-1:0] cnt;
    // reload on phase entry, then count down and hold at zero
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= WAIT_W'(WAIT_CYCLES);
        else if (cnt != '0) cnt <= cnt - WAIT_W'(1);
    end
`ifdef TINYRV_MEM_BRIDGE_RDY_EN
    assign done = (cnt == '0) && rdy;
`else
    logic unused_rdy;
    assign unused_rdy = rdy;
    assign done = (cnt == '0);
`endif
endmodule

// File: rtl/tinyrv_mem_bridge.sv
// tinyrv_mem_bridge: core request to byte-wide pin bus bridge; optional TINYRV_MEM_BRIDGE_RDY_EN adds ready stalls
module tinyrv_mem_bridge
    import tinyrv_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [7:0]  bus_addr_o,
    output logic        bus_ale_o,
    output logic        bus_byte_o,
    output logic        bus_rd_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_d_o,
    output logic [7:0]  bus_d_oe_o,
    input  logic [7:0]  bus_d_i,
    input  logic        bus_rdy_i
);
    state_t state, next;
    logic we_q;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic ctr_load, done;

    tinyrv_mem_bridge_wait_ctr #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk(clk),
        .rst(rst),
        .load(ctr_load),
        .rdy(bus_rdy_i),
        .done(done)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    // request capture and read byte assembly; a new accept clears stale read data
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q <= req_we;
                addr_q <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state == DATA_HI && done && !we_q) rdata_q[15:8] <= bus_d_i;
            if (state == DATA_LO && done && !we_q) rdata_q[7:0] <= bus_d_i;
        end
    end

    // next state and Moore bus/response outputs
    always_comb begin
        next = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        bus_addr_o = '0;
        bus_ale_o = 1'b0;
        bus_byte_o = BYTE_HI;
        bus_rd_o = 1'b0;
        bus_we_o = 1'b0;
        bus_d_o = '0;
        bus_d_oe_o = OE_RELEASE;
        ctr_load = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                next = req_valid ? ADDR_HI : IDLE;
            end
            ADDR_HI: begin
                bus_addr_o = addr_q[15:8];
                bus_ale_o = 1'b1;
                next = ADDR_LO;
            end
            ADDR_LO: begin
                bus_addr_o = addr_q[7:0];
                bus_ale_o = 1'b1;
                bus_byte_o = BYTE_LO;
                ctr_load = 1'b1;
                next = DATA_HI;
            end
            DATA_HI: begin
                bus_rd_o = !we_q;
                bus_we_o = we_q;
                bus_d_oe_o = we_q ? OE_DRIVE : OE_RELEASE;
                bus_d_o = we_q ? wdata_q[15:8] : 8'h00;
                ctr_load = done;
                next = done ? DATA_LO : DATA_HI;
            end
            DATA_LO: begin
                bus_byte_o = BYTE_LO;
                bus_rd_o = !we_q;
                bus_we_o = we_q;
                bus_d_oe_o = we_q ? OE_DRIVE : OE_RELEASE;
                bus_d_o = we_q ? wdata_q[7:0] : 8'h00;
                next = done ? RESP : DATA_LO;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = we_q ? 16'h0000 : rdata_q;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tinyrv_mem_bridge.sv
// tb_tinyrv_mem_bridge: table, random and corner-case checks of the bridge at WAIT_CYCLES 1, 0 and 15
module tb_tinyrv_mem_bridge;
    localparam int WS[3] = '{1, 0, 15};

    typedef struct {
        int          d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  dhi;
        logic [7:0]  dlo;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  ctl;
        logic [7:0]  d_o;
        logic [7:0]  oe;
        logic        rspv;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] rv;
    logic req_we;
    logic [15:0] req_addr, req_wdata;
    logic [7:0] bus_d_i;
    logic bus_rdy_i;

    logic ready_a[3], rspv_a[3], ale_a[3], byte_a[3], rd_a[3], we_a[3];
    logic [15:0] rdata_a[3];
    logic [7:0] addr_a[3], d_o_a[3], oe_a[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tinyrv_mem_bridge #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(ready_a[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a[0]), .rsp_rdata(rdata_a[0]),
        .bus_addr_o(addr_a[0]), .bus_ale_o(ale_a[0]), .bus_byte_o(byte_a[0]), .bus_rd_o(rd_a[0]),
        .bus_we_o(we_a[0]), .bus_d_o(d_o_a[0]), .bus_d_oe_o(oe_a[0]), .bus_d_i(bus_d_i),
        .bus_rdy_i(bus_rdy_i)
    );

    tinyrv_mem_bridge #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(ready_a[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a[1]), .rsp_rdata(rdata_a[1]),
        .bus_addr_o(addr_a[1]), .bus_ale_o(ale_a[1]), .bus_byte_o(byte_a[1]), .bus_rd_o(rd_a[1]),
        .bus_we_o(we_a[1]), .bus_d_o(d_o_a[1]), .bus_d_oe_o(oe_a[1]), .bus_d_i(bus_d_i),
        .bus_rdy_i(bus_rdy_i)
    );

    tinyrv_mem_bridge #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(ready_a[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a[2]), .rsp_rdata(rdata_a[2]),
        .bus_addr_o(addr_a[2]), .bus_ale_o(ale_a[2]), .bus_byte_o(byte_a[2]), .bus_rd_o(rd_a[2]),
        .bus_we_o(we_a[2]), .bus_d_o(d_o_a[2]), .bus_d_oe_o(oe_a[2]), .bus_d_i(bus_d_i),
        .bus_rdy_i(bus_rdy_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected outputs in cycle k after acceptance, from the transaction timeline:
    // 1 addr hi, 2 addr lo, 3..3+w data hi, 4+w..4+2w data lo, 5+2w response.
    function automatic exp_t model(vec_t v, int w, int k);
        exp_t e;
        logic hi, lo;
        e = '{default: '0};
        hi = (k >= 3) && (k <= 3 + w);
        lo = (k >= 4 + w) && (k <= 4 + 2 * w);
        if (k == 1) begin
            e.addr = v.addr[15:8];
            e.ctl = 4'b1000;
        end
        if (k == 2) begin
            e.addr = v.addr[7:0];
            e.ctl = 4'b1100;
        end
        if (hi || lo) begin
            e.ctl = {1'b0, lo, !v.we, v.we};
            e.oe = v.we ? 8'hFF : 8'h00;
            e.d_o = v.we ? (hi ? v.wdata[15:8] : v.wdata[7:0]) : 8'h00;
        end
        if (k == 5 + 2 * w) begin
            e.rspv = 1'b1;
            e.rdata = v.we ? 16'h0000 : {v.dhi, v.dlo};
        end
        return e;
    endfunction

    // Issue one request to instance v.d and check every cycle up to the response.
    // Read bytes appear on bus_d_i only on the last cycle of each data phase.
    task automatic run_txn(input vec_t v, input bit hold, output logic [15:0] got);
        int w;
        exp_t e;
        w = WS[v.d];
        got = 16'hxxxx;
        @(negedge clk);
        chk($sformatf("ready_idle d=%0d", v.d), 32'(ready_a[v.d]), 32'd1);
        rv[v.d] = 1'b1;
        req_we = v.we;
        req_addr = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        if (hold) begin
            req_addr = 16'h5555;
            req_we = 1'b0;
        end else rv[v.d] = 1'b0;
        for (int k = 1; k <= 5 + 2 * w; k++) begin
            if (!hold) begin
                req_we = 1'($urandom);
                req_addr = 16'($urandom);
                req_wdata = 16'($urandom);
            end
            bus_d_i = (k == 3 + w) ? v.dhi : (k == 4 + 2 * w) ? v.dlo : 8'($urandom);
            @(negedge clk);
            e = model(v, w, k);
            chk($sformatf("addr d=%0d k=%0d", v.d, k), 32'(addr_a[v.d]), 32'(e.addr));
            chk($sformatf("ctl d=%0d k=%0d", v.d, k),
                32'({ale_a[v.d], byte_a[v.d], rd_a[v.d], we_a[v.d]}), 32'(e.ctl));
            chk($sformatf("d_o d=%0d k=%0d", v.d, k), 32'(d_o_a[v.d]), 32'(e.d_o));
            chk($sformatf("oe d=%0d k=%0d", v.d, k), 32'(oe_a[v.d]), 32'(e.oe));
            chk($sformatf("rsp d=%0d k=%0d", v.d, k), 32'({rspv_a[v.d], rdata_a[v.d]}),
                32'({e.rspv, e.rdata}));
            chk($sformatf("ready_busy d=%0d k=%0d", v.d, k), 32'(ready_a[v.d]), 32'd0);
            if (rspv_a[v.d]) got = rdata_a[v.d];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        logic [15:0] got;
        int rsp_k, rsp_n;
        logic [15:0] rsp_d;

        tbl[0] = '{0, 1'b0, 16'h1234, 16'h0000, 8'hAB, 8'hCD, 16'hABCD};
        tbl[1] = '{0, 1'b1, 16'h00FF, 16'hBEEF, 8'h00, 8'h00, 16'h0000};
        tbl[2] = '{1, 1'b0, 16'h8001, 16'h0000, 8'h9E, 8'h01, 16'h9E01};
        tbl[3] = '{2, 1'b0, 16'h8001, 16'h0000, 8'h7F, 8'h80, 16'h7F80};
        tbl[4] = '{2, 1'b1, 16'hFFFF, 16'hA5C3, 8'h00, 8'h00, 16'h0000};

        rst = 1'b1;
        rv = '0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        bus_d_i = '0;
        bus_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset ready d=%0d", d), 32'(ready_a[d]), 32'd1);
            chk($sformatf("reset rsp d=%0d", d), 32'({rspv_a[d], rdata_a[d]}), 32'd0);
            chk($sformatf("reset bus d=%0d", d),
                32'({addr_a[d], ale_a[d], byte_a[d], rd_a[d], we_a[d]}), 32'd0);
            chk($sformatf("reset d_o/oe d=%0d", d), 32'({d_o_a[d], oe_a[d]}), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i], 1'b0, got);
            chk($sformatf("table rdata i=%0d", i), 32'(got), 32'(tbl[i].exp_rdata));
        end

        v = '{0, 1'b0, 16'h0A0B, 16'h0000, 8'h11, 8'h22, 16'h1122};
        run_txn(v, 1'b1, got);
        chk("held first rdata", 32'(got), 32'h1122);
        v = '{0, 1'b0, 16'h5555, 16'h0000, 8'h33, 8'h44, 16'h3344};
        run_txn(v, 1'b0, got);
        chk("held second rdata", 32'(got), 32'h3344);

        @(negedge clk);
        rv[0] = 1'b1;
        req_we = 1'b1;
        req_addr = 16'h0042;
        req_wdata = 16'h1357;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre-reset oe", 32'({oe_a[0], we_a[0]}), 32'h1FF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post-reset oe", 32'(oe_a[0]), 32'h0);
        chk("post-reset we/rsp", 32'({we_a[0], rspv_a[0]}), 32'h0);
        chk("post-reset ready", 32'(ready_a[0]), 32'd1);
        rsp_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rspv_a[0]) rsp_n++;
        end
        chk("post-reset no rsp", 32'(rsp_n), 32'd0);

        for (int i = 0; i < 24; i++) begin
            v.d = int'($urandom_range(0, 2));
            v.we = 1'($urandom);
            v.addr = 16'($urandom);
            v.wdata = 16'($urandom);
            v.dhi = 8'($urandom);
            v.dlo = 8'($urandom);
            v.exp_rdata = v.we ? 16'h0000 : {v.dhi, v.dlo};
            run_txn(v, 1'b0, got);
            chk($sformatf("rand rdata i=%0d", i), 32'(got), 32'(v.exp_rdata));
        end

`ifdef TINYRV_MEM_BRIDGE_RDY_EN
        @(negedge clk);
        rv[0] = 1'b1;
        req_we = 1'b0;
        req_addr = 16'h2468;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        rsp_k = 0;
        rsp_n = 0;
        rsp_d = '0;
        for (int k = 1; k <= 20; k++) begin
            bus_rdy_i = !(k >= 6 && k <= 9);
            bus_d_i = (k == 4) ? 8'h5A : (k == 10) ? 8'hC3 : 8'($urandom);
            @(negedge clk);
            if (k == 9) chk("rdy stall rd", 32'(rd_a[0]), 32'd1);
            if (rspv_a[0]) begin
                rsp_n++;
                rsp_k = k;
                rsp_d = rdata_a[0];
            end
            @(posedge clk);
            #1;
        end
        bus_rdy_i = 1'b1;
        chk("rdy rsp count", 32'(rsp_n), 32'd1);
        chk("rdy rsp cycle", 32'(rsp_k), 32'd11);
        chk("rdy rdata", 32'(rsp_d), 32'h5AC3);
`else
        rsp_k = 0;
        rsp_d = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
